// File: rtl/audio_word_sequencer.sv
// ---------------------------------------------------------------------------
// audio_word_sequencer
//
// Takes one DATA_W-bit word from the fetch controller and plays it out as a
// sequence of SAMPLE_W-bit slices, one slice per programmable sample period.
// Playback can run forward or backward through the slices and can skip every
// other slice. A one-cycle finish pulse tells the fetch controller that the
// next word may be supplied.
//
// Ports:
//   clk_i           system clock
//   reset_i         synchronous, active-high reset
//   start_i         request playback of data_i (honoured in IDLE or DONE)
//   data_i          word to play, slice k = data_i[k*SAMPLE_W +: SAMPLE_W]
//   period_i        clock cycles between samples (0 behaves as 1)
//   reverse_i       0: slices 0 upward, 1: slices NS-1 downward
//   stride2_i       0: every slice, 1: every other slice
//   audio_out_o     current sample, held between strobes
//   sample_strobe_o one-cycle pulse when audio_out_o takes a new value
//   sample_idx_o    slice index currently on audio_out_o
//   busy_o          high while a word is being played (LOAD, EMIT, WAIT)
//   finish_o        one-cycle pulse when the word is complete
// ---------------------------------------------------------------------------
module audio_word_sequencer #(
  parameter int DATA_W   = 32,
  parameter int SAMPLE_W = 8,
  parameter int DIV_W    = 16
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               start_i,
  input  logic [DATA_W-1:0]                  data_i,
  input  logic [DIV_W-1:0]                   period_i,
  input  logic                               reverse_i,
  input  logic                               stride2_i,
  output logic [SAMPLE_W-1:0]                audio_out_o,
  output logic                               sample_strobe_o,
  output logic [$clog2(DATA_W/SAMPLE_W)-1:0] sample_idx_o,
  output logic                               busy_o,
  output logic                               finish_o
);

  localparam int NS    = DATA_W / SAMPLE_W;
  localparam int IDX_W = $clog2(NS);
  localparam int CNT_W = IDX_W + 1;

  // The slice count must be a whole, even number of at least two so that the
  // every-other-slice mode always plays exactly NS/2 samples.
  if ((DATA_W % SAMPLE_W) != 0 || NS < 2 || (NS % 2) != 0) begin : g_param_check
    $error("audio_word_sequencer: DATA_W/SAMPLE_W must be an even integer >= 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EMIT,
    WAIT,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q;
  logic                reverse_q;
  logic                stride2_q;
  logic [DIV_W-1:0]    period_q;
  logic [DIV_W-1:0]    div_q;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W-1:0]    sampleIdx_q;
  logic [CNT_W-1:0]    count_q;
  logic [SAMPLE_W-1:0] audioOut_q;

  logic                startAccept;
  logic                allEmitted;
  logic                waitDone;
  logic                emitNow;
  logic [CNT_W-1:0]    sampleTotal;
  logic [IDX_W-1:0]    idxStep;
  logic [IDX_W-1:0]    idxNext;
  logic [IDX_W-1:0]    firstIdx;
  logic [SAMPLE_W-1:0] curSlice;

  // Helper terms shared by the next-state logic and the datapath.
  // count_q already includes the sample shown in the current EMIT cycle, so
  // comparing it to the total tells whether the word has been fully played.
  // The WAIT counter starts at 0, so P-1 waiting cycles have elapsed when
  // div_q+1 reaches P-1.
  always_comb begin
    startAccept = start_i && (state_q == IDLE || state_q == DONE);
    sampleTotal = stride2_q ? CNT_W'(NS / 2) : CNT_W'(NS);
    allEmitted  = (count_q == sampleTotal);
    waitDone    = ((div_q + DIV_W'(1)) == (period_q - DIV_W'(1)));
    idxStep     = stride2_q ? IDX_W'(2) : IDX_W'(1);
    idxNext     = reverse_q ? (idx_q - idxStep) : (idx_q + idxStep);
    firstIdx    = reverse_i ? IDX_W'(NS - 1) : '0;
  end

  // Slice selector: picks the slice addressed by idx_q out of the latched word.
  always_comb begin
    curSlice = '0;
    for (int k = 0; k < NS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        curSlice = data_q[k*SAMPLE_W +: SAMPLE_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. With a one-cycle period EMIT chains straight into the
  // next EMIT; otherwise every sample is followed by a WAIT stretch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = EMIT;
      end
      EMIT: begin
        if (period_q > DIV_W'(1)) begin
          state_d = WAIT;
        end else if (allEmitted) begin
          state_d = DONE;
        end else begin
          state_d = EMIT;
        end
      end
      WAIT: begin
        if (waitDone) begin
          state_d = allEmitted ? DONE : EMIT;
        end
      end
      DONE: begin
        state_d = start_i ? LOAD : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign emitNow = (state_d == EMIT);

  // Datapath. Playback settings are captured on the same edge that accepts
  // start, so the LOAD cycle already holds a valid first index and the first
  // slice can be presented on the edge leaving LOAD. The output register is
  // updated on every edge into EMIT so audio_out and the strobe line up in
  // the same cycle. The index is not advanced past the final sample, so it
  // never wraps.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q      <= '0;
      reverse_q   <= 1'b0;
      stride2_q   <= 1'b0;
      period_q    <= DIV_W'(1);
      div_q       <= '0;
      idx_q       <= '0;
      sampleIdx_q <= '0;
      count_q     <= '0;
      audioOut_q  <= '0;
    end else begin
      if (startAccept) begin
        data_q    <= data_i;
        reverse_q <= reverse_i;
        stride2_q <= stride2_i;
        period_q  <= (period_i == '0) ? DIV_W'(1) : period_i;
        idx_q     <= firstIdx;
        count_q   <= '0;
      end
      if (emitNow) begin
        audioOut_q  <= curSlice;
        sampleIdx_q <= idx_q;
        count_q     <= count_q + CNT_W'(1);
        if ((count_q + CNT_W'(1)) != sampleTotal) begin
          idx_q <= idxNext;
        end
      end
      div_q <= (state_q == WAIT) ? (div_q + DIV_W'(1)) : '0;
    end
  end

  // Output decode.
  always_comb begin
    audio_out_o     = audioOut_q;
    sample_idx_o    = sampleIdx_q;
    sample_strobe_o = (state_q == EMIT);
    busy_o          = (state_q == LOAD) || (state_q == EMIT) || (state_q == WAIT);
    finish_o        = (state_q == DONE);
  end

endmodule

// File: tb/tb_audio_word_sequencer.sv
// ---------------------------------------------------------------------------
// tb_audio_word_sequencer
//
// Scoreboard bench for audio_word_sequencer. Two instances are exercised: the
// default 32/8 configuration and a 48/8 configuration with six slices.
// Directed words are issued from the main initial block, which pushes the
// hand-computed samples (value, index, cycle) and finish cycles into queues.
// A negedge monitor pops and compares whenever a strobe or finish appears.
// ---------------------------------------------------------------------------
module tb_audio_word_sequencer;

  typedef struct {
    logic [15:0] audio;
    int          idx;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        reset;
  int          cyc = 0;
  int          testsRun = 0;
  int          testsFailed = 0;
  int          finSeenA = 0;
  int          finSeenB = 0;

  exp_t        expA[$];
  exp_t        expB[$];
  int          finA[$];
  int          finB[$];
  exp_t        eA;
  exp_t        eB;

  // Instance A: 32-bit word, 8-bit samples.
  logic        startA;
  logic [31:0] dataA;
  logic [15:0] periodA;
  logic        reverseA;
  logic        stride2A;
  logic [7:0]  audioA;
  logic        strobeA;
  logic [1:0]  idxA;
  logic        busyA;
  logic        finishA;

  // Instance B: 48-bit word, 8-bit samples (six slices).
  logic        startB;
  logic [47:0] dataB;
  logic [15:0] periodB;
  logic        reverseB;
  logic        stride2B;
  logic [7:0]  audioB;
  logic        strobeB;
  logic [2:0]  idxB;
  logic        busyB;
  logic        finishB;

  audio_word_sequencer #(
    .DATA_W  (32),
    .SAMPLE_W(8),
    .DIV_W   (16)
  ) dutA (
    .clk_i          (clk),
    .reset_i        (reset),
    .start_i        (startA),
    .data_i         (dataA),
    .period_i       (periodA),
    .reverse_i      (reverseA),
    .stride2_i      (stride2A),
    .audio_out_o    (audioA),
    .sample_strobe_o(strobeA),
    .sample_idx_o   (idxA),
    .busy_o         (busyA),
    .finish_o       (finishA)
  );

  audio_word_sequencer #(
    .DATA_W  (48),
    .SAMPLE_W(8),
    .DIV_W   (16)
  ) dutB (
    .clk_i          (clk),
    .reset_i        (reset),
    .start_i        (startB),
    .data_i         (dataB),
    .period_i       (periodB),
    .reverse_i      (reverseB),
    .stride2_i      (stride2B),
    .audio_out_o    (audioB),
    .sample_strobe_o(strobeB),
    .sample_idx_o   (idxB),
    .busy_o         (busyB),
    .finish_o       (finishB)
  );

  // Free-running clock and cycle counter; cyc names the cycle that begins at
  // each rising edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point: every check counts as one test.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) tick();
  endtask

  task automatic pushA(input logic [15:0] audio, input int idx, input int at);
    exp_t e;
    e.audio = audio;
    e.idx   = idx;
    e.cyc   = at;
    expA.push_back(e);
  endtask

  task automatic pushB(input logic [15:0] audio, input int idx, input int at);
    exp_t e;
    e.audio = audio;
    e.idx   = idx;
    e.cyc   = at;
    expB.push_back(e);
  endtask

  // Drives start for exactly one cycle on the chosen instance, starting in
  // the current cycle, and returns that cycle number.
  task automatic applyStimulus(input bit useB, input logic [47:0] d, input logic [15:0] p,
                               input bit rev, input bit s2, output int c);
    c = cyc;
    if (useB) begin
      dataB = d; periodB = p; reverseB = rev; stride2B = s2; startB = 1'b1;
    end else begin
      dataA = d[31:0]; periodA = p; reverseA = rev; stride2A = s2; startA = 1'b1;
    end
    tick();
    startA = 1'b0;
    startB = 1'b0;
  endtask

  // Waits (bounded) for every pending expectation to be consumed.
  task automatic waitDrain(input int maxCycles);
    int n = 0;
    while ((expA.size() + finA.size() + expB.size() + finB.size()) != 0 && n < maxCycles) begin
      tick();
      n++;
    end
    checkOutput("drain_pending", 64'(expA.size() + finA.size() + expB.size() + finB.size()), 64'd0);
  endtask

  // Monitor: compares strobes and finish pulses against the scoreboard.
  always @(negedge clk) begin
    if (strobeA) begin
      if (expA.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL A_unexpected_strobe: got strobe with %0h at cycle %0d, expected none", audioA, cyc);
      end else begin
        eA = expA.pop_front();
        checkOutput("A_audio", 64'(audioA), 64'(eA.audio));
        checkOutput("A_idx", 64'(idxA), 64'(eA.idx));
        checkOutput("A_strobe_cycle", 64'(cyc), 64'(eA.cyc));
      end
    end
    if (finishA) begin
      finSeenA++;
      checkOutput("A_busy_with_finish", 64'(busyA), 64'd0);
      if (finA.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL A_unexpected_finish: got finish at cycle %0d, expected none", cyc);
      end else begin
        checkOutput("A_finish_cycle", 64'(cyc), 64'(finA.pop_front()));
      end
    end
    if (strobeB) begin
      if (expB.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL B_unexpected_strobe: got strobe with %0h at cycle %0d, expected none", audioB, cyc);
      end else begin
        eB = expB.pop_front();
        checkOutput("B_audio", 64'(audioB), 64'(eB.audio));
        checkOutput("B_idx", 64'(idxB), 64'(eB.idx));
        checkOutput("B_strobe_cycle", 64'(cyc), 64'(eB.cyc));
      end
    end
    if (finishB) begin
      finSeenB++;
      checkOutput("B_busy_with_finish", 64'(busyB), 64'd0);
      if (finB.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL B_unexpected_finish: got finish at cycle %0d, expected none", cyc);
      end else begin
        checkOutput("B_finish_cycle", 64'(cyc), 64'(finB.pop_front()));
      end
    end
  end

  // Directed stimulus sequence.
  initial begin
    int c;
    int finBefore;

    reset = 1'b1;
    startA = 1'b0; dataA = '0; periodA = '0; reverseA = 1'b0; stride2A = 1'b0;
    startB = 1'b0; dataB = '0; periodB = '0; reverseB = 1'b0; stride2B = 1'b0;
    repeat (3) tick();
    checkOutput("A_reset_outputs", 64'({audioA, idxA, strobeA, busyA, finishA}), 64'd0);
    checkOutput("B_reset_outputs", 64'({audioB, idxB, strobeB, busyB, finishB}), 64'd0);
    reset = 1'b0;

    // Idle with start low: nothing moves.
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("A_idle_outputs", 64'({audioA, idxA, strobeA, busyA, finishA}), 64'd0);
    end

    // Forward, every slice, P=3.
    applyStimulus(1'b0, 48'hAABBCCDD, 16'd3, 1'b0, 1'b0, c);
    pushA(16'hDD, 0, c + 2);
    pushA(16'hCC, 1, c + 5);
    pushA(16'hBB, 2, c + 8);
    pushA(16'hAA, 3, c + 11);
    finA.push_back(c + 14);
    checkOutput("A_busy_in_load", 64'(busyA), 64'd1);
    waitUntil(c + 14);
    checkOutput("A_busy_in_done", 64'(busyA), 64'd0);
    waitDrain(100);

    // Reverse, every other slice, P=2273; start and data change while busy.
    tick();
    applyStimulus(1'b0, 48'hAABBCCDD, 16'd2273, 1'b1, 1'b1, c);
    pushA(16'hAA, 3, c + 2);
    pushA(16'hCC, 1, c + 2275);
    finA.push_back(c + 4548);
    waitUntil(c + 10);
    dataA = 32'h0;
    startA = 1'b1;
    tick();
    startA = 1'b0;
    waitUntil(c + 20);
    checkOutput("A_hold_while_busy", 64'(audioA), 64'hAA);
    checkOutput("A_busy_mid_word", 64'(busyA), 64'd1);
    dataA = 32'hAABBCCDD;
    waitDrain(6000);
    repeat (10) tick();
    checkOutput("A_idle_after_word", 64'(busyA), 64'd0);

    // Period 0 behaves as 1; start held in DONE chains the next word.
    applyStimulus(1'b0, 48'hAABBCCDD, 16'd0, 1'b0, 1'b0, c);
    pushA(16'hDD, 0, c + 2);
    pushA(16'hCC, 1, c + 3);
    pushA(16'hBB, 2, c + 4);
    pushA(16'hAA, 3, c + 5);
    finA.push_back(c + 6);
    waitUntil(c + 6);
    checkOutput("A_finish_before_chain", 64'(finishA), 64'd1);
    pushA(16'h11, 0, c + 8);
    pushA(16'h22, 1, c + 9);
    pushA(16'h33, 2, c + 10);
    pushA(16'h44, 3, c + 11);
    finA.push_back(c + 12);
    applyStimulus(1'b0, 48'h44332211, 16'd0, 1'b0, 1'b0, finBefore);
    waitDrain(100);

    // Reverse, every slice, P=2.
    tick();
    applyStimulus(1'b0, 48'hAABBCCDD, 16'd2, 1'b1, 1'b0, c);
    pushA(16'hAA, 3, c + 2);
    pushA(16'hBB, 2, c + 4);
    pushA(16'hCC, 1, c + 6);
    pushA(16'hDD, 0, c + 8);
    finA.push_back(c + 10);
    waitDrain(100);

    // Reset during the WAIT after the second sample abandons the word.
    tick();
    applyStimulus(1'b0, 48'h01020304, 16'd5, 1'b0, 1'b0, c);
    pushA(16'h04, 0, c + 2);
    pushA(16'h03, 1, c + 7);
    waitUntil(c + 9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("A_after_reset_audio", 64'(audioA), 64'd0);
    checkOutput("A_after_reset_idx", 64'(idxA), 64'd0);
    checkOutput("A_after_reset_ctrl", 64'({strobeA, busyA, finishA}), 64'd0);
    finBefore = finSeenA;
    repeat (3000) tick();
    checkOutput("A_no_finish_after_reset", 64'(finSeenA), 64'(finBefore));
    checkOutput("A_samples_before_reset", 64'(expA.size()), 64'd0);

    // Six-slice instance: reverse, every slice, P=4.
    applyStimulus(1'b1, 48'h112233445566, 16'd4, 1'b1, 1'b0, c);
    pushB(16'h11, 5, c + 2);
    pushB(16'h22, 4, c + 6);
    pushB(16'h33, 3, c + 10);
    pushB(16'h44, 2, c + 14);
    pushB(16'h55, 1, c + 18);
    pushB(16'h66, 0, c + 22);
    finB.push_back(c + 26);
    waitDrain(200);

    // Six-slice instance: forward, every other slice, P=1.
    tick();
    applyStimulus(1'b1, 48'h112233445566, 16'd1, 1'b0, 1'b1, c);
    pushB(16'h66, 0, c + 2);
    pushB(16'h44, 2, c + 3);
    pushB(16'h22, 4, c + 4);
    finB.push_back(c + 5);
    waitDrain(100);

    repeat (5) tick();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
